kbd_tone_gen: RTL and testbench
===============================

Name: kbd_tone_gen

Overview:
- Consumes the held 8-bit PS/2 set-2 scan code from the keyboard front end (key_8; 0 = no key) and produces a 16-bit signed audio sample stream for the audio codec interface.
- Maps eight keys to notes C4..C5.
- Runs a phase accumulator through a triangle-wave generator.
- Shapes amplitude with an attack/sustain/release envelope FSM.

Parameters:
- ATTACK_STEP, 64, envelope increment per sample in ATTACK (32767/64 = 512 samples, ≈10.7 ms @48 kHz)
- RELEASE_STEP, 16, envelope decrement per sample in RELEASE (≈2048 samples)
- LEVEL_MAX, 32767, sustain envelope level (15-bit unsigned, ≤ 32767)

Ports:
- clk  in  1  system clock
- clr  in  1  reset: synchronous, active-high
- sample_en  in  1  one-clk strobe at the sample rate (48 kHz); spacing ≥ 3 clk
- key_8  in  8  current pressed scan code, 0 = none
- sample_out  out  16  signed sample, held between strobes
- sample_valid  out  1  one-clk pulse when sample_out updates
- note_on  out  1  high in ATTACK or SUSTAIN
- active_key  out  8  scan code currently sounding, 0 in IDLE

Behaviour:
- Reset (clr=1 at posedge):
  - state=IDLE; phase, inc, env, sample_out, active_key = 0; sample_valid=0; note_on=0.
  - clr overrides everything in progress, including a pending pipeline sample.
- Note map (key -> code -> inc, for a 16-bit accumulator, inc = round(f*65536/48000)):
  - A 1C -> 357, S 1B -> 401, D 23 -> 450, F 2B -> 477, G 34 -> 535, H 33 -> 601, J 3B -> 674, K 42 -> 714.
  - Any other code, including 0, is "unmapped".
- All FSM/phase/env decisions happen only on sample_en cycles; key_8 is sampled on that cycle.
- FSM states: IDLE, ATTACK, SUSTAIN, RELEASE.
  - IDLE: env=0, phase=0. Mapped key: latch inc and active_key -> ATTACK. Unmapped: stay.
  - ATTACK: env += ATTACK_STEP, computed 16-bit and saturated to LEVEL_MAX; on reaching LEVEL_MAX -> SUSTAIN.
  - SUSTAIN: env held.
  - ATTACK/SUSTAIN, same mapped key: continue.
  - ATTACK/SUSTAIN, different mapped key: relatch inc and active_key -> ATTACK from current env; phase continuous, no reset.
  - ATTACK/SUSTAIN, unmapped key: -> RELEASE; inc and active_key retained.
  - RELEASE: env -= RELEASE_STEP, saturating at 0; at 0 -> IDLE, with phase and active_key cleared in the same update.
  - RELEASE, mapped key: latch inc and active_key -> ATTACK from current env.
- Phase: phase <= phase + inc, mod 2^16, on every sample_en where state ≠ IDLE, using the inc latched that cycle.
- Waveform:
  - tri_u = phase[15] ? ~{phase[14:0],0} : {phase[14:0],0}
  - tri_s = tri_u ^ 16'h8000
  - sample = (tri_s * env), 32-bit signed product, arithmetic >>> 15, low 16 bits. No overflow, since env ≤ 32767.
- Pipeline:
  - Cycle T (sample_en): FSM/phase/env update.
  - T+1: multiply registered.
  - T+2: sample_out updates and sample_valid=1 for exactly one clk.
  - sample_valid pulses for every sample_en, including in IDLE, where the output is 0.
- Simultaneous events: a clr coinciding with sample_en wins; no sample is produced for that strobe.

Decomposition:
- Package kbd_tone_pkg:
  - state enum
  - eight scan-code constants
  - eight phase-increment constants
  - widths PHASE_W=16, SAMPLE_W=16
- Sub-module key_note_lut: combinational scan code -> {valid, inc[15:0]}, reused by any later key-driven block.

Test Plan:
- Reset: clr=1 for 2 clk, then sample_en strobes with key_8=0 -> sample_out=0, sample_valid pulses at T+2, note_on=0, active_key=0.
- Press: key_8=1C, sample_en every 4 clk.
  - active_key=1C after the 1st strobe.
  - Phase after N strobes = N*357 mod 65536.
  - env reaches 32767 exactly at strobe 512 -> SUSTAIN.
  - Check the forced phase point phase=0 with env=32767 -> sample = -32767.
- Release: key_8 1C -> 0 in SUSTAIN.
  - env drops 16 per strobe; IDLE after 2048 strobes.
  - note_on=0 from the first release strobe.
  - phase=0 and sample_out=0 afterwards.
- Unmapped: key_8=8'h29 in IDLE -> stays IDLE, active_key=0, sample_valid still pulses, with sample_out=0.
- Retrigger: in SUSTAIN switch key_8 1C -> 42 directly.
  - inc=714, active_key=42.
  - ATTACK saturates and returns to SUSTAIN on the next strobe.
  - Phase is continuous, with no jump to 0.
- Mid-operation reset: clr=1 during RELEASE, coincident with sample_en -> all outputs 0 next clk, no sample_valid for that strobe, IDLE thereafter.

Source files
------------

// File: rtl/kbd_tone_gen_pkg.sv
// Shared types and constants for the keyboard tone generator and any other
// key-driven blocks: FSM states, PS/2 set-2 codes and note phase increments.
package kbd_tone_pkg;
    localparam int PHASE_W  = 16;
    localparam int SAMPLE_W = 16;
    localparam int ENV_W    = 16;

    typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} state_t;

    localparam logic [7:0] KEY_A = 8'h1C;
    localparam logic [7:0] KEY_S = 8'h1B;
    localparam logic [7:0] KEY_D = 8'h23;
    localparam logic [7:0] KEY_F = 8'h2B;
    localparam logic [7:0] KEY_G = 8'h34;
    localparam logic [7:0] KEY_H = 8'h33;
    localparam logic [7:0] KEY_J = 8'h3B;
    localparam logic [7:0] KEY_K = 8'h42;

    // round(f * 65536 / 48000) for C4..C5
    localparam logic [PHASE_W-1:0] INC_A = 16'd357;
    localparam logic [PHASE_W-1:0] INC_S = 16'd401;
    localparam logic [PHASE_W-1:0] INC_D = 16'd450;
    localparam logic [PHASE_W-1:0] INC_F = 16'd477;
    localparam logic [PHASE_W-1:0] INC_G = 16'd535;
    localparam logic [PHASE_W-1:0] INC_H = 16'd601;
    localparam logic [PHASE_W-1:0] INC_J = 16'd674;
    localparam logic [PHASE_W-1:0] INC_K = 16'd714;
endpackage

// File: rtl/kbd_tone_gen_if.sv
// Sample-strobe / key input and audio-sample output bundle of the tone generator.
interface kbd_tone_gen_if;
    logic                                  sample_en;
    logic [7:0]                            key_8;
    logic signed [kbd_tone_pkg::SAMPLE_W-1:0] sample_out;
    logic                                  sample_valid;
    logic                                  note_on;
    logic [7:0]                            active_key;

    modport master (output sample_en, key_8,
                    input  sample_out, sample_valid, note_on, active_key);
    modport slave  (input  sample_en, key_8,
                    output sample_out, sample_valid, note_on, active_key);
endinterface

// File: rtl/kbd_tone_gen_key_note_lut.sv
// Scan code to phase increment lookup; valid is low for any unmapped code.
module key_note_lut
    import kbd_tone_pkg::*;
(
    input  logic [7:0]         code,
    output logic               valid,
    output logic [PHASE_W-1:0] inc
);
    always_comb begin
        valid = 1'b1;
        inc   = '0;
        case (code)
            KEY_A:   inc = INC_A;
            KEY_S:   inc = INC_S;
            KEY_D:   inc = INC_D;
            KEY_F:   inc = INC_F;
            KEY_G:   inc = INC_G;
            KEY_H:   inc = INC_H;
            KEY_J:   inc = INC_J;
            KEY_K:   inc = INC_K;
            default: valid = 1'b0;
        endcase
    end
endmodule

// File: rtl/kbd_tone_gen.sv
// Key-driven triangle tone generator: phase accumulator, ASR envelope FSM and a
// two-stage output pipeline (state update at T, sample registered for T+2).
module kbd_tone_gen
    import kbd_tone_pkg::*;
#(
    parameter logic [ENV_W-1:0] ATTACK_STEP  = 16'd64,
    parameter logic [ENV_W-1:0] RELEASE_STEP = 16'd16,
    parameter logic [ENV_W-1:0] LEVEL_MAX    = 16'd32767
) (
    input  logic           clk,
    input  logic           clr,
    kbd_tone_gen_if.slave  bus
);
    localparam int STAGES = 2;

    state_t                state_q, state_d;
    logic [PHASE_W-1:0]    phase_q, phase_d;
    logic [PHASE_W-1:0]    inc_q, inc_d;
    logic [ENV_W-1:0]      env_q, env_d;
    logic [7:0]            key_q, key_d;
    logic [SAMPLE_W-1:0]   sample_q, sample_d;
    logic [STAGES:1]       vld_pipe_q, vld_pipe_d;

    logic                  key_hit;
    logic [PHASE_W-1:0]    key_inc;
    logic [ENV_W-1:0]      env_up, env_dn;
    logic [15:0]           tri_u, tri_s;
    logic signed [31:0]    prod;

    key_note_lut u_lut (.code(bus.key_8), .valid(key_hit), .inc(key_inc));

    assign env_up = (env_q + ATTACK_STEP >= LEVEL_MAX) ? LEVEL_MAX : env_q + ATTACK_STEP;
    assign env_dn = (env_q > RELEASE_STEP) ? env_q - RELEASE_STEP : '0;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        inc_d   = inc_q;
        env_d   = env_q;
        key_d   = key_q;
        if (bus.sample_en) begin
            case (state_q)
                IDLE: begin
                    env_d = '0;
                    if (key_hit) begin
                        inc_d   = key_inc;
                        key_d   = bus.key_8;
                        state_d = ATTACK;
                    end
                end
                ATTACK, SUSTAIN: begin
                    if (!key_hit) begin
                        state_d = RELEASE;
                    end else if (bus.key_8 != key_q) begin
                        // retrigger keeps current env and phase, only the pitch changes
                        inc_d   = key_inc;
                        key_d   = bus.key_8;
                        state_d = ATTACK;
                    end else if (state_q == ATTACK) begin
                        env_d = env_up;
                        if (env_up == LEVEL_MAX) state_d = SUSTAIN;
                    end
                end
                RELEASE: begin
                    if (key_hit) begin
                        inc_d   = key_inc;
                        key_d   = bus.key_8;
                        state_d = ATTACK;
                    end else begin
                        env_d = env_dn;
                        if (env_dn == '0) begin
                            state_d = IDLE;
                            key_d   = '0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
            phase_d = (state_d == IDLE) ? '0 : phase_q + inc_d;
        end
    end

    // Triangle from phase, then signed scale by the envelope (Q15).
    always_comb begin
        tri_u    = phase_q[15] ? ~{phase_q[14:0], 1'b0} : {phase_q[14:0], 1'b0};
        tri_s    = tri_u ^ 16'h8000;
        prod     = $signed({{16{tri_s[15]}}, tri_s}) * $signed({16'b0, env_q});
        sample_d = vld_pipe_q[1] ? SAMPLE_W'(prod >>> 15) : sample_q;
        vld_pipe_d = {vld_pipe_q[STAGES-1:1], bus.sample_en};
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            inc_q      <= '0;
            env_q      <= '0;
            key_q      <= '0;
            sample_q   <= '0;
            vld_pipe_q <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            inc_q      <= inc_d;
            env_q      <= env_d;
            key_q      <= key_d;
            sample_q   <= sample_d;
            vld_pipe_q <= vld_pipe_d;
        end
    end

    assign bus.sample_out   = sample_q;
    assign bus.sample_valid = vld_pipe_q[STAGES];
    assign bus.note_on      = (state_q == ATTACK) || (state_q == SUSTAIN);
    assign bus.active_key   = key_q;
endmodule

// File: tb/tb_kbd_tone_gen.sv
// Randomized plus directed bench for kbd_tone_gen against a behavioural note/envelope model.
module tb_kbd_tone_gen;
    localparam int M_IDLE = 0, M_ATT = 1, M_SUS = 2, M_REL = 3;

    logic clk = 1'b0;
    logic clr;
    kbd_tone_gen_if bus();

    kbd_tone_gen dut (.clk(clk), .clr(clr), .bus(bus));

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int m_st, m_env, m_phase, m_inc, m_key, m_sample;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            if (n_fail <= 25) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int note_inc(input int code);
        case (code)
            'h1C: return 357;
            'h1B: return 401;
            'h23: return 450;
            'h2B: return 477;
            'h34: return 535;
            'h33: return 601;
            'h3B: return 674;
            'h42: return 714;
            default: return 0;
        endcase
    endfunction

    function automatic int wave(input int ph, input int env);
        int tu, ts;
        tu = (ph < 32768) ? 2 * ph : 65535 - 2 * (ph - 32768);
        ts = tu - 32768;
        return (ts * env) >>> 15;
    endfunction

    task automatic model_reset();
        m_st = M_IDLE; m_env = 0; m_phase = 0; m_inc = 0; m_key = 0; m_sample = 0;
    endtask

    task automatic model_step(input int key);
        int ni;
        ni = note_inc(key);
        if (m_st == M_IDLE) begin
            m_env = 0;
            if (ni != 0) begin m_inc = ni; m_key = key; m_st = M_ATT; end
        end else if (m_st == M_REL) begin
            if (ni != 0) begin m_inc = ni; m_key = key; m_st = M_ATT; end
            else begin
                m_env = (m_env > 16) ? m_env - 16 : 0;
                if (m_env == 0) begin m_st = M_IDLE; m_key = 0; end
            end
        end else begin
            if (ni == 0) m_st = M_REL;
            else if (key != m_key) begin m_inc = ni; m_key = key; m_st = M_ATT; end
            else if (m_st == M_ATT) begin
                m_env = (m_env + 64 > 32767) ? 32767 : m_env + 64;
                if (m_env == 32767) m_st = M_SUS;
            end
        end
        m_phase  = (m_st == M_IDLE) ? 0 : (m_phase + m_inc) % 65536;
        m_sample = wave(m_phase, m_env);
    endtask

    task automatic strobe(input logic [7:0] key, input int gap);
        @(negedge clk);
        bus.key_8 = key;
        bus.sample_en = 1'b1;
        @(posedge clk);
        model_step(int'(key));
        #1;
        bus.sample_en = 1'b0;
        chk("note_on", int'(bus.note_on), (m_st == M_ATT || m_st == M_SUS) ? 1 : 0);
        chk("active_key", int'(bus.active_key), m_key);
        chk("valid_early", int'(bus.sample_valid), 0);
        @(posedge clk); #1;
        chk("valid", int'(bus.sample_valid), 1);
        chk("sample", int'($signed(bus.sample_out)), m_sample);
        @(posedge clk); #1;
        chk("valid_drop", int'(bus.sample_valid), 0);
        repeat (gap - 3) @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr = 1'b1; bus.sample_en = 1'b0; bus.key_8 = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        clr = 1'b0;
    endtask

    logic [7:0] pool [12] = '{8'h00, 8'h00, 8'h1C, 8'h1B, 8'h23, 8'h2B,
                             8'h34, 8'h33, 8'h3B, 8'h42, 8'h29, 8'h5A};

    initial begin
        int n, ph_before, hold;
        logic [7:0] k;
        clr = 1'b0; bus.sample_en = 1'b0; bus.key_8 = 8'h00;
        model_reset();

        // reset state
        do_reset();
        chk("rst_sample", int'($signed(bus.sample_out)), 0);
        chk("rst_valid", int'(bus.sample_valid), 0);
        chk("rst_note_on", int'(bus.note_on), 0);
        chk("rst_active", int'(bus.active_key), 0);
        repeat (3) strobe(8'h00, 4);

        // unmapped code in IDLE stays silent but still emits samples
        repeat (3) strobe(8'h29, 4);
        chk("unmapped_phase", int'(dut.phase_q), 0);

        // press A through attack into sustain
        n = 0;
        while (m_st != M_SUS && n < 700) begin strobe(8'h1C, 4); n++; end
        chk("press_phase", int'(dut.phase_q), (n * 357) % 65536);
        chk("press_env", int'(dut.env_q), 32767);
        repeat (5) strobe(8'h1C, 4);

        // retrigger to K straight from sustain
        ph_before = int'(dut.phase_q);
        strobe(8'h42, 4);
        chk("retrig_key", int'(bus.active_key), 'h42);
        chk("retrig_phase", int'(dut.phase_q), (ph_before + 714) % 65536);
        strobe(8'h42, 4);
        chk("retrig_sustain", int'(dut.state_q), int'(kbd_tone_pkg::SUSTAIN));
        chk("retrig_env", int'(dut.env_q), 32767);

        // release to idle
        n = 0;
        while (m_st != M_IDLE && n < 2200) begin strobe(8'h00, 4); n++; end
        chk("rel_phase", int'(dut.phase_q), 0);
        chk("rel_env", int'(dut.env_q), 0);
        repeat (2) strobe(8'h00, 4);

        // randomized key sequences
        for (int it = 0; it < 40; it++) begin
            k = pool[$urandom_range(0, 11)];
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(200, 600) : $urandom_range(1, 30);
            for (int h = 0; h < hold; h++) strobe(k, $urandom_range(3, 6));
        end

        // mid-release reset coincident with a strobe
        n = 0;
        while (m_st != M_SUS && n < 700) begin strobe(8'h34, 4); n++; end
        repeat (50) strobe(8'h00, 4);
        @(negedge clk);
        clr = 1'b1; bus.sample_en = 1'b1; bus.key_8 = 8'h00;
        @(posedge clk); #1;
        bus.sample_en = 1'b0;
        model_reset();
        chk("clr_sample", int'($signed(bus.sample_out)), 0);
        chk("clr_valid", int'(bus.sample_valid), 0);
        chk("clr_note_on", int'(bus.note_on), 0);
        chk("clr_active", int'(bus.active_key), 0);
        chk("clr_env", int'(dut.env_q), 0);
        @(posedge clk); #1;
        chk("clr_valid_t1", int'(bus.sample_valid), 0);
        @(posedge clk); #1;
        chk("clr_valid_t2", int'(bus.sample_valid), 0);
        clr = 1'b0;
        repeat (3) strobe(8'h00, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
